// File: rtl/lut_mem_pkg.sv
// Shared constants and init-value helper for the lut_mem lookup table.
// Init values are computed wide and narrowed by the caller.
package lut_mem_pkg;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;
    localparam int VAL_W   = 64;

    // mode 0: every entry takes the fill word; otherwise entry i holds i
    function automatic logic [VAL_W-1:0] init_val(
        input int                idx,
        input int                mode,
        input logic [VAL_W-1:0]  fill
    );
        if (mode == 0) begin
            return fill;
        end
        return VAL_W'(unsigned'(idx));
    endfunction

endpackage

// File: rtl/lut_mem_rd_pipe.sv
// Read-result pipeline: optional extra stage plus the held output register.
// Output data/err only change when a valid result arrives.
module lut_mem_rd_pipe
    import lut_mem_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                READ_LAT  = 1,
    parameter logic [DATA_W-1:0] RESET_OUT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_data
);

    logic              w_valid;
    logic              w_err;
    logic [DATA_W-1:0] w_data;

    logic              r_out_valid;
    logic              r_out_err;
    logic [DATA_W-1:0] r_out_data;

    if (READ_LAT == LAT_MAX) begin : g_stage
        logic              r_valid;
        logic              r_err;
        logic [DATA_W-1:0] r_data;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= i_valid;
                r_err   <= i_err;
                r_data  <= i_data;
            end
        end

        assign w_valid = r_valid;
        assign w_err   = r_err;
        assign w_data  = r_data;
    end else begin : g_bypass
        assign w_valid = i_valid;
        assign w_err   = i_err;
        assign w_data  = i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= RESET_OUT;
        end else begin
            r_out_valid <= w_valid;
            if (w_valid) begin
                r_out_err  <= w_err;
                r_out_data <= w_data;
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_err   = r_out_err;
    assign o_data  = r_out_data;

endmodule

// File: rtl/lut_mem.sv
// Flop-based parametrised lookup table with registered read port,
// synchronous write port and out-of-range read flagging.
module lut_mem
    import lut_mem_pkg::*;
#(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter int                READ_LAT  = 1,
    parameter int                INIT_MODE = 1,
    parameter logic [DATA_W-1:0] FILL      = '1,
    parameter logic [DATA_W-1:0] RESET_OUT = DATA_W'(8'h80)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err
);

    if (READ_LAT < LAT_MIN || READ_LAT > LAT_MAX) begin : g_bad_lat
        $error("lut_mem: READ_LAT must be 1 or 2");
    end

    if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("lut_mem: DEPTH must be within 2 .. 2**ADDR_W");
    end

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_rd_oob;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd_word;

    assign w_rd_oob = {1'b0, rd_addr} >= LIMIT;
    assign w_wr_ok  = wr_en && ({1'b0, wr_addr} < LIMIT);

    // array is sampled before the write lands: read-first
    assign w_rd_word = w_rd_oob ? FILL : r_mem[rd_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(init_val(i, INIT_MODE, 64'(FILL)));
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    lut_mem_rd_pipe #(
        .DATA_W    (DATA_W),
        .READ_LAT  (READ_LAT),
        .RESET_OUT (RESET_OUT)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (rd_en),
        .i_err   (rd_en & w_rd_oob),
        .i_data  (w_rd_word),
        .o_valid (rd_valid),
        .o_err   (rd_err),
        .o_data  (rd_data)
    );

endmodule

// File: tb/tb_lut_mem.sv
// Self-checking bench for lut_mem across four parameter sets.
// Expected values come from plain arrays modelling table contents.
module tb_lut_mem;

    logic clk = 1'b0;
    logic reset;

    logic       rd_en0, wr_en0, rd_valid0, rd_err0;
    logic [3:0] rd_addr0, wr_addr0;
    logic [7:0] wr_data0, rd_data0;

    logic       rd_en1, wr_en1, rd_valid1, rd_err1;
    logic [3:0] rd_addr1, wr_addr1;
    logic [7:0] wr_data1, rd_data1;

    logic       rd_en2, wr_en2, rd_valid2, rd_err2;
    logic [3:0] rd_addr2, wr_addr2;
    logic [7:0] wr_data2, rd_data2;

    logic       rd_en3, wr_en3, rd_valid3, rd_err3;
    logic [5:0] rd_addr3, wr_addr3;
    logic [3:0] wr_data3, rd_data3;

    logic [7:0] m0 [16];
    logic [7:0] m1 [12];
    logic [7:0] m2 [16];
    logic [3:0] m3 [40];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_mem u0 (
        .clk(clk), .reset(reset),
        .rd_en(rd_en0), .rd_addr(rd_addr0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_err(rd_err0)
    );

    lut_mem #(.DEPTH(12), .INIT_MODE(0)) u1 (
        .clk(clk), .reset(reset),
        .rd_en(rd_en1), .rd_addr(rd_addr1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_err(rd_err1)
    );

    lut_mem #(.READ_LAT(2)) u2 (
        .clk(clk), .reset(reset),
        .rd_en(rd_en2), .rd_addr(rd_addr2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_err(rd_err2)
    );

    lut_mem #(.ADDR_W(6), .DATA_W(4), .DEPTH(40)) u3 (
        .clk(clk), .reset(reset),
        .rd_en(rd_en3), .rd_addr(rd_addr3),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .rd_err(rd_err3)
    );

    task automatic init_models();
        for (int i = 0; i < 16; i++) m0[i] = 8'(i);
        for (int i = 0; i < 12; i++) m1[i] = 8'hFF;
        for (int i = 0; i < 16; i++) m2[i] = 8'(i);
        for (int i = 0; i < 40; i++) m3[i] = 4'(i);
    endtask

    task automatic idle_all();
        rd_en0 = 0; wr_en0 = 0; rd_addr0 = 0; wr_addr0 = 0; wr_data0 = 0;
        rd_en1 = 0; wr_en1 = 0; rd_addr1 = 0; wr_addr1 = 0; wr_data1 = 0;
        rd_en2 = 0; wr_en2 = 0; rd_addr2 = 0; wr_addr2 = 0; wr_data2 = 0;
        rd_en3 = 0; wr_en3 = 0; rd_addr3 = 0; wr_addr3 = 0; wr_data3 = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        init_models();
        checks++;
        if ({rd_valid0, rd_err0, rd_data0} !== {2'b00, 8'h80}) begin
            errors++;
            $display("FAIL reset_u0: got %b%b_%h expected 00_80",
                     rd_valid0, rd_err0, rd_data0);
        end
        checks++;
        if ({rd_valid1, rd_err1, rd_data1} !== {2'b00, 8'h80}) begin
            errors++;
            $display("FAIL reset_u1: got %b%b_%h expected 00_80",
                     rd_valid1, rd_err1, rd_data1);
        end
        checks++;
        if ({rd_valid2, rd_err2, rd_data2} !== {2'b00, 8'h80}) begin
            errors++;
            $display("FAIL reset_u2: got %b%b_%h expected 00_80",
                     rd_valid2, rd_err2, rd_data2);
        end
        checks++;
        if ({rd_valid3, rd_err3, rd_data3} !== {2'b00, 4'h0}) begin
            errors++;
            $display("FAIL reset_u3: got %b%b_%h expected 00_0",
                     rd_valid3, rd_err3, rd_data3);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_valid0, rd_data0} !== {1'b0, 8'h80}) begin
            errors++;
            $display("FAIL post_reset_idle: got %b_%h expected 0_80",
                     rd_valid0, rd_data0);
        end
    endtask

    task automatic test_seq_read();
        logic [3:0] a [4];
        a = '{4'd0, 4'd1, 4'd15, 4'd7};
        rd_en0 = 1; rd_addr0 = a[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rd_valid0, rd_err0, rd_data0} !== {2'b10, m0[a[i]]}) begin
                errors++;
                $display("FAIL seq_read%0d: got %b%b_%h expected 10_%h",
                         i, rd_valid0, rd_err0, rd_data0, m0[a[i]]);
            end
            if (i < 3) rd_addr0 = a[i+1];
            else rd_en0 = 0;
        end
        @(negedge clk);
        checks++;
        if ({rd_valid0, rd_data0} !== {1'b0, 8'h07}) begin
            errors++;
            $display("FAIL seq_hold: got %b_%h expected 0_07",
                     rd_valid0, rd_data0);
        end
    endtask

    task automatic test_range();
        rd_en1 = 1; rd_addr1 = 4'd3;
        @(negedge clk);
        checks++;
        if ({rd_valid1, rd_err1, rd_data1} !== {2'b10, 8'hFF}) begin
            errors++;
            $display("FAIL range_in: got %b%b_%h expected 10_ff",
                     rd_valid1, rd_err1, rd_data1);
        end
        rd_addr1 = 4'd13;
        @(negedge clk);
        checks++;
        if ({rd_valid1, rd_err1, rd_data1} !== {2'b11, 8'hFF}) begin
            errors++;
            $display("FAIL range_oob: got %b%b_%h expected 11_ff",
                     rd_valid1, rd_err1, rd_data1);
        end
        rd_en1 = 0; wr_en1 = 1; wr_addr1 = 4'd14; wr_data1 = 8'h5A;
        @(negedge clk);
        checks++;
        if ({rd_valid1, rd_err1, rd_data1} !== {2'b01, 8'hFF}) begin
            errors++;
            $display("FAIL range_hold: got %b%b_%h expected 01_ff",
                     rd_valid1, rd_err1, rd_data1);
        end
        wr_en1 = 0; rd_en1 = 1; rd_addr1 = 4'd14;
        @(negedge clk);
        rd_en1 = 0;
        checks++;
        if ({rd_valid1, rd_err1, rd_data1} !== {2'b11, 8'hFF}) begin
            errors++;
            $display("FAIL range_dropwr: got %b%b_%h expected 11_ff",
                     rd_valid1, rd_err1, rd_data1);
        end
    endtask

    task automatic test_rdw_lat1();
        logic [7:0] old_v;
        old_v = m0[4];
        rd_en0 = 1; rd_addr0 = 4'd4;
        wr_en0 = 1; wr_addr0 = 4'd4; wr_data0 = 8'hA5;
        m0[4] = 8'hA5;
        @(negedge clk);
        wr_en0 = 0;
        checks++;
        if ({rd_valid0, rd_err0, rd_data0} !== {2'b10, old_v}) begin
            errors++;
            $display("FAIL rdw1_old: got %b%b_%h expected 10_%h",
                     rd_valid0, rd_err0, rd_data0, old_v);
        end
        @(negedge clk);
        rd_en0 = 0;
        checks++;
        if ({rd_valid0, rd_err0, rd_data0} !== {2'b10, m0[4]}) begin
            errors++;
            $display("FAIL rdw1_new: got %b%b_%h expected 10_%h",
                     rd_valid0, rd_err0, rd_data0, m0[4]);
        end
    endtask

    task automatic test_stream_lat2();
        rd_en2 = 1; rd_addr2 = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            checks++;
            if (k >= 2 && k <= 17) begin
                if ({rd_valid2, rd_err2, rd_data2} !== {2'b10, m2[k-2]}) begin
                    errors++;
                    $display("FAIL stream%0d: got %b%b_%h expected 10_%h",
                             k, rd_valid2, rd_err2, rd_data2, m2[k-2]);
                end
            end else if (rd_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL stream_edge%0d: got valid %b expected 0",
                         k, rd_valid2);
            end
            if (k < 16) rd_addr2 = 4'(k);
            else rd_en2 = 0;
        end
    endtask

    task automatic test_rdw_lat2();
        logic [7:0] old_v;
        old_v = m2[4];
        rd_en2 = 1; rd_addr2 = 4'd4;
        wr_en2 = 1; wr_addr2 = 4'd4; wr_data2 = 8'hA5;
        m2[4] = 8'hA5;
        @(negedge clk);
        wr_en2 = 0;
        checks++;
        if (rd_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL rdw2_lat: got valid %b expected 0", rd_valid2);
        end
        @(negedge clk);
        rd_en2 = 0;
        checks++;
        if ({rd_valid2, rd_err2, rd_data2} !== {2'b10, old_v}) begin
            errors++;
            $display("FAIL rdw2_old: got %b%b_%h expected 10_%h",
                     rd_valid2, rd_err2, rd_data2, old_v);
        end
        @(negedge clk);
        checks++;
        if ({rd_valid2, rd_err2, rd_data2} !== {2'b10, m2[4]}) begin
            errors++;
            $display("FAIL rdw2_new: got %b%b_%h expected 10_%h",
                     rd_valid2, rd_err2, rd_data2, m2[4]);
        end
    endtask

    task automatic test_reset_inflight();
        rd_en2 = 1; rd_addr2 = 4'd4;
        @(posedge clk);
        #2;
        reset = 1'b1;
        rd_en2 = 0;
        #1;
        checks++;
        if ({rd_valid2, rd_err2, rd_data2} !== {2'b00, 8'h80}) begin
            errors++;
            $display("FAIL async_reset: got %b%b_%h expected 00_80",
                     rd_valid2, rd_err2, rd_data2);
        end
        @(negedge clk);
        reset = 1'b0;
        init_models();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rd_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL flushed%0d: got valid %b expected 0",
                         k, rd_valid2);
            end
        end
        rd_en2 = 1; rd_addr2 = 4'd4;
        rd_en0 = 1; rd_addr0 = 4'd4;
        @(negedge clk);
        rd_en0 = 0; rd_en2 = 0;
        checks++;
        if ({rd_valid0, rd_err0, rd_data0} !== {2'b10, m0[4]}) begin
            errors++;
            $display("FAIL reinit_u0: got %b%b_%h expected 10_%h",
                     rd_valid0, rd_err0, rd_data0, m0[4]);
        end
        @(negedge clk);
        checks++;
        if ({rd_valid2, rd_err2, rd_data2} !== {2'b10, m2[4]}) begin
            errors++;
            $display("FAIL reinit_u2: got %b%b_%h expected 10_%h",
                     rd_valid2, rd_err2, rd_data2, m2[4]);
        end
    endtask

    task automatic test_wide();
        rd_en3 = 1; rd_addr3 = 6'd37;
        @(negedge clk);
        checks++;
        if ({rd_valid3, rd_err3, rd_data3} !== {2'b10, m3[37]}) begin
            errors++;
            $display("FAIL wide_trunc: got %b%b_%h expected 10_%h",
                     rd_valid3, rd_err3, rd_data3, m3[37]);
        end
        rd_addr3 = 6'd40;
        @(negedge clk);
        rd_en3 = 0;
        checks++;
        if ({rd_valid3, rd_err3, rd_data3} !== {2'b11, 4'hF}) begin
            errors++;
            $display("FAIL wide_oob: got %b%b_%h expected 11_f",
                     rd_valid3, rd_err3, rd_data3);
        end
    endtask

    task automatic test_random();
        logic       v1, e1, h1_e, n_v, n_e, o_v, o_e, h2_e;
        logic [7:0] d1, h1_d, n_d, o_d, h2_d;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        init_models();
        v1 = 0; e1 = 0; d1 = 0; h1_e = 0; h1_d = 8'h80;
        n_v = 0; n_e = 0; n_d = 0; o_v = 0; o_e = 0; o_d = 0;
        h2_e = 0; h2_d = 8'h80;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (v1) begin h1_e = e1; h1_d = d1; end
            checks++;
            if ({rd_valid1, rd_err1, rd_data1} !== {v1, h1_e, h1_d}) begin
                errors++;
                $display("FAIL rand_u1 c%0d: got %b%b_%h expected %b%b_%h",
                         c, rd_valid1, rd_err1, rd_data1, v1, h1_e, h1_d);
            end
            if (o_v) begin h2_e = o_e; h2_d = o_d; end
            checks++;
            if ({rd_valid2, rd_err2, rd_data2} !== {o_v, h2_e, h2_d}) begin
                errors++;
                $display("FAIL rand_u2 c%0d: got %b%b_%h expected %b%b_%h",
                         c, rd_valid2, rd_err2, rd_data2, o_v, h2_e, h2_d);
            end
            o_v = n_v; o_e = n_e; o_d = n_d;
            rd_en1 = ($urandom_range(0, 3) != 0);
            rd_addr1 = 4'($urandom_range(0, 15));
            wr_en1 = $urandom_range(0, 1) == 1;
            wr_addr1 = 4'($urandom_range(0, 15));
            wr_data1 = 8'($urandom);
            rd_en2 = ($urandom_range(0, 3) != 0);
            rd_addr2 = 4'($urandom_range(0, 15));
            wr_en2 = $urandom_range(0, 1) == 1;
            wr_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr2
                                                   : 4'($urandom_range(0, 15));
            wr_data2 = 8'($urandom);
            v1 = rd_en1;
            e1 = rd_addr1 >= 12;
            d1 = e1 ? 8'hFF : m1[rd_addr1];
            if (wr_en1 && wr_addr1 < 12) m1[wr_addr1] = wr_data1;
            n_v = rd_en2;
            n_e = 1'b0;
            n_d = m2[rd_addr2];
            if (wr_en2) m2[wr_addr2] = wr_data2;
        end
        @(negedge clk);
        idle_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        test_reset();
        test_seq_read();
        test_range();
        test_rdw_lat1();
        test_stream_lat2();
        test_rdw_lat2();
        test_reset_inflight();
        test_wide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
